// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, byte FIFO, serializer.
// States: IDLE | line high, waiting for FIFO data; START | start bit; DATA | 8 data bits LSB first; STOP | stop bit
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [29:0]   DATA_WA   = BASE_ADDR[31:2];
  localparam logic [29:0]   STAT_WA   = BASE_ADDR[31:2] + 30'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d, idx_nxt;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  logic sel_data, sel_stat, full, empty, bit_end, pop, push_req, push;

  assign sel_data = (DataAdr[31:2] == DATA_WA);
  assign sel_stat = (DataAdr[31:2] == STAT_WA);
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign bit_end  = (cnt_q == CNT_LAST);
  assign idx_nxt  = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
            tx_d  = shift_q[idx_nxt];
          end
        end
      end
      default: begin
        if (bit_end) begin
          cnt_d = '0;
          // Back-to-back frames: reload straight into START, no idle bit.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  assign push_req = MemWrite & sel_data;
  assign push     = push_req & (~full | pop);

  always_comb begin
    ovf_d = ovf_q;
    if (MemWrite && sel_stat) ovf_d = 1'b0;
    else if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  assign uart_tx = tx_q;
  assign busy    = ~empty | (state_q != S_IDLE);

  always_comb begin
    ReadData = '0;
    if (sel_stat) ReadData[3:0] = {ovf_q, empty, busy, full};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a timeline model of FIFO pops and frame bits
// predicts uart_tx, busy and STATUS every cycle.
module tb_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h100;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .uart_tx(uart_tx), .busy(busy)
  );

  // Reference model: queue of accepted bytes plus the time the line becomes free.
  logic [7:0] m_q[$];
  int         m_cyc = 0;
  int         m_free = 0;
  int         m_pop = 0;
  logic [7:0] m_cur = '0;
  logic       m_ovf = 1'b0;

  function automatic logic exp_tx();
    int k;
    if (m_cyc >= m_free) return 1'b1;
    k = (m_cyc - m_pop) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (m_q.size() != 0) || (m_cyc < m_free);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_q.size() == DEPTH);
    s[1] = exp_busy();
    s[2] = (m_q.size() == 0);
    s[3] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] adr);
    if ((adr >> 2) == ((BASE + 32'd4) >> 2)) return exp_status();
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cyc = 0;
    m_free = 0;
    m_pop = 0;
    m_ovf = 1'b0;
  endtask

  task automatic set_in(input logic we, input logic [31:0] adr, input logic [31:0] data);
    MemWrite = we;
    DataAdr = adr;
    WriteData = data;
  endtask

  // One clock: model consumes the inputs seen at the rising edge, returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    m_cyc++;
    if (m_q.size() != 0 && m_cyc >= m_free) begin
      m_cur = m_q.pop_front();
      m_pop = m_cyc;
      m_free = m_cyc + FRAME;
    end
    if (MemWrite && (DataAdr >> 2) == (BASE >> 2)) begin
      if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
      else m_ovf = 1'b1;
    end
    if (MemWrite && (DataAdr >> 2) == ((BASE + 32'd4) >> 2)) m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    set_in(1'b0, BASE + 32'd4, 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      #1;
      total++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || ReadData !== 32'h4) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d tx=%b busy=%b rd=%h want 1 0 00000004", i, uart_tx, busy, ReadData);
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] pat;
    pat = 10'b1000011010;
    set_in(1'b1, BASE, 32'h0000_000D);
    tick();
    set_in(1'b0, BASE + 32'd4, 32'd0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      total++;
      if (uart_tx !== pat[i/CPB] || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_frame cyc=%0d tx=%b busy=%b want tx=%b busy=1", i, uart_tx, busy, pat[i/CPB]);
      end
    end
    tick();
    #1;
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || ReadData !== 32'h4) begin
      bad++;
      $display("FAIL single_end tx=%b busy=%b rd=%h want 1 0 00000004", uart_tx, busy, ReadData);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [6];
    vals = '{8'd13, 8'd7, 8'd30, 8'd3, 8'hAA, 8'h55};
    for (int j = 0; j < 6; j++) begin
      set_in(1'b1, BASE, {24'd0, vals[j]});
      tick();
      total++;
      if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL ovf_push j=%0d tx=%b busy=%b want %b %b", j, uart_tx, busy, exp_tx(), exp_busy());
      end
    end
    set_in(1'b0, BASE + 32'd4, 32'd0);
    #1;
    total++;
    if (ReadData !== 32'hB || ReadData !== exp_status()) begin
      bad++;
      $display("FAIL ovf_status rd=%h want 0000000b", ReadData);
    end
    for (int i = 0; i < 5 * FRAME + 5; i++) begin
      tick();
      total++;
      if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL ovf_drain cyc=%0d tx=%b busy=%b want %b %b", i, uart_tx, busy, exp_tx(), exp_busy());
      end
    end
    set_in(1'b1, BASE + 32'd4, 32'hFFFF_FFFF);
    tick();
    set_in(1'b0, BASE + 32'd4, 32'd0);
    #1;
    total++;
    if (ReadData !== 32'h4) begin
      bad++;
      $display("FAIL ovf_clear rd=%h want 00000004", ReadData);
    end
  endtask

  task automatic test_unmapped();
    set_in(1'b1, BASE + 32'd8, $urandom);
    tick();
    set_in(1'b1, BASE - 32'd4, $urandom);
    tick();
    set_in(1'b0, BASE + 32'd8, 32'd0);
    #1;
    total++;
    if (ReadData !== 32'd0) begin
      bad++;
      $display("FAIL unmapped_rd108 rd=%h want 00000000", ReadData);
    end
    set_in(1'b0, BASE - 32'd4, 32'd0);
    #1;
    total++;
    if (ReadData !== 32'd0) begin
      bad++;
      $display("FAIL unmapped_rd0fc rd=%h want 00000000", ReadData);
    end
    set_in(1'b0, BASE, 32'd0);
    #1;
    total++;
    if (ReadData !== 32'd0) begin
      bad++;
      $display("FAIL txdata_rd rd=%h want 00000000", ReadData);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if (uart_tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL unmapped_quiet cyc=%0d tx=%b busy=%b want 1 0", i, uart_tx, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    set_in(1'b1, BASE, 32'hFF);
    tick();
    set_in(1'b1, BASE, {24'd0, 8'($urandom)});
    tick();
    set_in(1'b1, BASE, {24'd0, 8'($urandom)});
    tick();
    set_in(1'b0, BASE + 32'd4, 32'd0);
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      total++;
      if (uart_tx !== exp_tx()) begin
        bad++;
        $display("FAIL rstmid_pre cyc=%0d tx=%b want %b", i, uart_tx, exp_tx());
      end
      if (m_cyc == m_pop + 5 * CPB + 1) hit = 1'b1;
    end
    total++;
    if (!hit || uart_tx !== 1'b1 || m_q.size() != 2) begin
      bad++;
      $display("FAIL rstmid_reach hit=%0d tx=%b queued=%0d want 1 1 2", hit, uart_tx, m_q.size());
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async tx=%b busy=%b want 1 0", uart_tx, busy);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      #1;
      total++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || ReadData !== 32'h4) begin
        bad++;
        $display("FAIL rstmid_after cyc=%0d tx=%b busy=%b rd=%h want 1 0 00000004", i, uart_tx, busy, ReadData);
      end
    end
  endtask

  task automatic test_full_boundary();
    bit hit;
    hit = 1'b0;
    for (int j = 0; j < 5; j++) begin
      set_in(1'b1, BASE, {24'd0, 8'($urandom)});
      tick();
    end
    set_in(1'b0, BASE + 32'd4, 32'd0);
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_cyc + 1 == m_free && m_q.size() == DEPTH) hit = 1'b1;
      else begin
        tick();
        total++;
        if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
          bad++;
          $display("FAIL full_wait cyc=%0d tx=%b busy=%b want %b %b", i, uart_tx, busy, exp_tx(), exp_busy());
        end
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL full_reach hit=0 want 1");
    end
    #1;
    total++;
    if (ReadData !== 32'h3) begin
      bad++;
      $display("FAIL full_status rd=%h want 00000003", ReadData);
    end
    set_in(1'b1, BASE, {24'd0, 8'($urandom)});
    tick();
    set_in(1'b0, BASE + 32'd4, 32'd0);
    #1;
    total++;
    if (ReadData[3] !== 1'b0 || ReadData[0] !== 1'b1 || ReadData !== exp_status()) begin
      bad++;
      $display("FAIL full_same_cycle rd=%h want %h (ovf 0, full 1)", ReadData, exp_status());
    end
    for (int i = 0; i < (DEPTH + 1) * FRAME + 10; i++) begin
      tick();
      total++;
      if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL full_drain cyc=%0d tx=%b busy=%b want %b %b", i, uart_tx, busy, exp_tx(), exp_busy());
      end
    end
    total++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL full_done tx=%b busy=%b want 1 0", uart_tx, busy);
    end
  endtask

  task automatic test_random();
    int op;
    int gap;
    logic [31:0] adr;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 45) : $urandom_range(0, 2);
      if (op <= 5) set_in(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
      else if (op == 6) set_in(1'b1, BASE + 32'd4, $urandom);
      else if (op == 7) set_in(1'b1, BASE + 32'd8 + 32'($urandom_range(0, 15) * 4), $urandom);
      else set_in(1'b0, BASE + 32'd4, 32'd0);
      for (int g = 0; g <= gap; g++) begin
        #1;
        total++;
        if (ReadData !== exp_rd(DataAdr)) begin
          bad++;
          $display("FAIL rand_read adr=%h rd=%h want %h", DataAdr, ReadData, exp_rd(DataAdr));
        end
        tick();
        total++;
        if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
          bad++;
          $display("FAIL rand_line op=%0d tx=%b busy=%b want %b %b", n, uart_tx, busy, exp_tx(), exp_busy());
        end
        case ($urandom_range(0, 3))
          0: adr = BASE;
          1: adr = BASE + 32'd4;
          2: adr = BASE + 32'd8;
          default: adr = $urandom;
        endcase
        set_in(1'b0, adr, 32'd0);
      end
    end
    for (int i = 0; i < (DEPTH + 1) * FRAME + 10; i++) begin
      tick();
      total++;
      if (uart_tx !== exp_tx() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL rand_drain cyc=%0d tx=%b busy=%b want %b %b", i, uart_tx, busy, exp_tx(), exp_busy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_unmapped();
    test_reset_mid();
    test_full_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
